// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter: FSM states, frame width and line levels.
package serial_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
  localparam int   DATA_BITS  = 8;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;
endpackage

// File: rtl/serial_fifo.sv
// Byte FIFO with wrapping pointers; the extra pointer bit separates full from empty.
module serial_fifo
  import serial_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]          wptr_q, rptr_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic                 do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/serial_tx.sv
// Buffered UART transmitter, 8N1 by default; define SERIAL_TX_PARITY_EN for an even
// parity bit between data and stop (8E1).
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  output logic                 tx,
  output logic                 busy,
  output logic                 full,
  output logic                 overflow
);
  state_e               state_q;
  logic [15:0]          cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shreg_q, head;
  logic                 tx_q, tx_d, ovf_q, empty, pop, bit_done;
`ifdef SERIAL_TX_PARITY_EN
  logic                 par_q;
`endif

  serial_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .push_i  (start),
    .wdata_i (data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bit_done = (cnt_q == 16'(CLKS_PER_BIT - 1));
  assign pop      = !empty && ((state_q == ST_IDLE) || (state_q == ST_STOP && bit_done));

  // The line level is registered from the state, so tx trails the FSM by one cycle.
  always_comb begin
    tx_d = LINE_IDLE;
    case (state_q)
      ST_START:  tx_d = LINE_START;
      ST_DATA:   tx_d = shreg_q[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: tx_d = par_q;
`endif
      ST_STOP:   tx_d = LINE_STOP;
      default:   tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;
      if (state_q != ST_IDLE) cnt_q <= bit_done ? '0 : cnt_q + 1'b1;
      if (pop) begin
        shreg_q <= head;
`ifdef SERIAL_TX_PARITY_EN
        par_q   <= ^head;
`endif
      end
      case (state_q)
        ST_IDLE:  if (!empty) state_q <= ST_START;
        ST_START: if (bit_done) state_q <= ST_DATA;
        ST_DATA: if (bit_done) begin
          shreg_q <= shreg_q >> 1;
          idx_q   <= idx_q + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          if (idx_q == 3'(DATA_BITS - 1)) state_q <= ST_PARITY;
`else
          if (idx_q == 3'(DATA_BITS - 1)) state_q <= ST_STOP;
`endif
        end
        ST_PARITY: if (bit_done) state_q <= ST_STOP;
        // Back-to-back frames: a queued byte goes straight to START with no idle gap.
        ST_STOP:  if (bit_done) state_q <= empty ? ST_IDLE : ST_START;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)            ovf_q <= 1'b0;
    else if (start && full) ovf_q <= 1'b1;
  end

  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE) || !empty;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: table-driven single frames, burst/overflow/reset
// sequences, and randomized bursts decoded by a line-level UART receiver model.
module tb_serial_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       sysclk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, busy, full, overflow;
  int         errors = 0, checks = 0;

  serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .data     (data),
    .start    (start),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected line level of frame bit b: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && NB == 11) return p;
    return 1'b1;
  endfunction

  // Compares every cycle of a frame; samples before k0 were already taken by the caller.
  task automatic check_frame(input logic [7:0] d, input logic p, input int k0, input bit adv);
    int bad = 0;
    if (adv) @(negedge sysclk);
    for (int k = k0; k < NB*CPB; k++) begin
      if (k != k0) @(negedge sysclk);
      if (tx !== exp_bit(d, p, k / CPB)) bad++;
    end
    chk($sformatf("frame_%02h_bad_cycles", d), bad, 0);
  endtask

  // Single push; returns number of negedges after the sampling edge until tx is low.
  task automatic push_one(input logic [7:0] d, output int lat);
    @(negedge sysclk); data = d; start = 1'b1;
    @(negedge sysclk); start = 1'b0;
    lat = 1;
    while (tx !== 1'b0 && lat < 200) begin
      @(negedge sysclk); lat++;
    end
  endtask

  logic s_tx [8], s_full [8], s_ovf [8];
  task automatic burst(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      s_tx[i] = tx; s_full[i] = full; s_ovf[i] = overflow;
      data = base + 8'(i); start = 1'b1;
    end
    @(negedge sysclk); start = 1'b0;
    s_tx[n] = tx; s_full[n] = full; s_ovf[n] = overflow;
  endtask

  // Receiver model: decodes frames at mid-bit into rx_q while mon_en is set.
  logic       mon_en = 1'b0;
  logic [7:0] rx_q [$];
  int         frame_err = 0;
  always begin : rx_mon
    logic [7:0] b;
    @(negedge sysclk);
    if (mon_en && tx === 1'b0) begin
      repeat (CPB/2) @(negedge sysclk);
      if (tx !== 1'b0) frame_err++;
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge sysclk);
        b[j] = tx;
      end
`ifdef SERIAL_TX_PARITY_EN
      repeat (CPB) @(negedge sysclk);
      if (tx !== ^b) frame_err++;
`endif
      repeat (CPB) @(negedge sysclk);
      if (tx !== 1'b1) frame_err++;
      rx_q.push_back(b);
    end
  end

  typedef struct {
    logic [7:0] d;
    int         lat;
    logic       par;
  } vec_t;

  initial begin
    vec_t       vt [6];
    logic [7:0] exp_q [$];
    int         lat, lows, cnt, pushed;

    vt[0] = '{8'h31, 3, 1'b1};
    vt[1] = '{8'h33, 3, 1'b0};
    vt[2] = '{8'h00, 3, 1'b0};
    vt[3] = '{8'hFF, 3, 1'b0};
    vt[4] = '{8'hA5, 3, 1'b0};
    vt[5] = '{8'h80, 3, 1'b1};

    repeat (3) @(negedge sysclk);
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
    chk("rst_full", full, 0); chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    // Single frames: tx low two edges after the sampling edge, exact bit timing, busy drops.
    foreach (vt[i]) begin
      push_one(vt[i].d, lat);
      chk($sformatf("latency_%02h", vt[i].d), lat, vt[i].lat);
      chk($sformatf("busy_in_frame_%02h", vt[i].d), busy, 1);
      check_frame(vt[i].d, vt[i].par, 0, 1'b0);
      @(negedge sysclk);
      chk($sformatf("busy_after_%02h", vt[i].d), busy, 0);
      chk($sformatf("tx_idle_after_%02h", vt[i].d), tx, 1);
      repeat (5) @(negedge sysclk);
    end

    // Four consecutive pushes: first byte already popped, so never full; frames contiguous.
    burst(8'h30, 4);
    chk("b4_tx_before_start", s_tx[2], 1);
    chk("b4_tx_start_low", s_tx[3], 0);
    chk("b4_full", s_full[4], 0);
    check_frame(8'h30, ^8'h30, 1, 1'b0);
    for (int i = 1; i < 4; i++) check_frame(8'h30 + 8'(i), ^(8'h30 + 8'(i)), 0, 1'b1);
    @(negedge sysclk);
    chk("b4_busy_after", busy, 0);
    repeat (5) @(negedge sysclk);

    // Six consecutive pushes: FIFO fills after the fifth, sixth dropped, overflow sticky.
    burst(8'h40, 6);
    chk("b6_full_before_5th", s_full[4], 0);
    chk("b6_full_after_5th", s_full[5], 1);
    chk("b6_ovf_before_drop", s_ovf[5], 0);
    chk("b6_ovf_after_drop", s_ovf[6], 1);
    check_frame(8'h40, ^8'h40, 3, 1'b0);
    for (int i = 1; i < 5; i++) check_frame(8'h40 + 8'(i), ^(8'h40 + 8'(i)), 0, 1'b1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sysclk);
      if (tx !== 1'b1) lows++;
    end
    chk("b6_no_sixth_frame", lows, 0);
    chk("b6_busy_after", busy, 0);
    chk("b6_ovf_sticky", overflow, 1);

    // Reset during data bit 3 of 0x75, then a clean frame pushed on the first edge after release.
    push_one(8'h75, lat);
    chk("rst_mid_latency", lat, 3);
    repeat (4*CPB + CPB/2) @(negedge sysclk);
    chk("rst_mid_bit3_low", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1); chk("rst_mid_busy", busy, 0);
    chk("rst_mid_full", full, 0); chk("rst_mid_ovf", overflow, 0);
    lows = 0;
    repeat (3) begin
      @(negedge sysclk);
      if (tx !== 1'b1) lows++;
    end
    chk("rst_hold_tx_high", lows, 0);
    rst_n = 1'b1; data = 8'h39; start = 1'b1;
    @(negedge sysclk); start = 1'b0;
    lat = 1;
    while (tx !== 1'b0 && lat < 200) begin
      @(negedge sysclk); lat++;
    end
    chk("post_rst_latency", lat, 3);
    check_frame(8'h39, ^8'h39, 0, 1'b0);
    @(negedge sysclk);
    chk("post_rst_busy", busy, 0);
    repeat (5) @(negedge sysclk);

    // Randomized bursts: 20 bytes cycling 0x30..0x39 then 20 random, all must arrive in order.
    mon_en = 1'b1;
    pushed = 0;
    while (pushed < 40) begin
      int n = $urandom_range(1, 4);
      for (int i = 0; i < n && pushed < 40; i++) begin
        logic [7:0] v = (pushed < 20) ? 8'h30 + 8'(pushed % 10) : 8'($urandom);
        @(negedge sysclk); data = v; start = 1'b1;
        exp_q.push_back(v);
        pushed++;
      end
      @(negedge sysclk); start = 1'b0;
      cnt = 0;
      while (busy !== 1'b0 && cnt < 1000) begin
        @(negedge sysclk); cnt++;
      end
      if (cnt >= 1000) chk("rand_idle_timeout", cnt, 0);
      repeat (2*CPB) @(negedge sysclk);
    end
    mon_en = 1'b0;
    chk("rand_rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("rand_byte_%0d", i), rx_q[i], exp_q[i]);
    chk("rand_frame_errors", frame_err, 0);
    chk("rand_no_overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
